// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
// Module   : pipe_ctrl_unit
// Purpose  : 5-stage MIPS control: ID decode, ID/EX-EX/MEM-MEM/WB control
//            pipeline, load-use / RAW stall, branch flush, EX forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit #(
  parameter int ALUC_W = 6,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_inst,
  input  logic              id_valid,
  input  logic              branch_taken,
  output logic              cu_stall,
  output logic              cu_flush,
  output logic              cu_illegal,
  output logic              ex_wreg,
  output logic              ex_m2reg,
  output logic              ex_wmem,
  output logic              ex_aluimm,
  output logic              ex_shift,
  output logic              ex_sext,
  output logic              ex_branch,
  output logic              ex_bne,
  output logic [ALUC_W-1:0] ex_aluc,
  output logic [REG_AW-1:0] ex_dst,
  output logic              mem_wreg,
  output logic              mem_m2reg,
  output logic              mem_wmem,
  output logic [REG_AW-1:0] mem_dst,
  output logic              wb_wreg,
  output logic              wb_m2reg,
  output logic [REG_AW-1:0] wb_dst,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_SLTI  = 6'h0a;
  localparam logic [5:0] C_OP_ANDI  = 6'h0c;
  localparam logic [5:0] C_OP_ORI   = 6'h0d;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2b;

  localparam logic [ALUC_W-1:0] C_ALU_ADD = ALUC_W'(6'h20);
  localparam logic [ALUC_W-1:0] C_ALU_SUB = ALUC_W'(6'h22);
  localparam logic [ALUC_W-1:0] C_ALU_AND = ALUC_W'(6'h24);
  localparam logic [ALUC_W-1:0] C_ALU_OR  = ALUC_W'(6'h25);
  localparam logic [ALUC_W-1:0] C_ALU_SLT = ALUC_W'(6'h2a);

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              aluimm;
    logic              shift;
    logic              sext;
    logic              branch;
    logic              bne;
    logic [ALUC_W-1:0] aluc;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } ctl_t;

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic              unused_shamt;

  assign w_op         = id_inst[31:26];
  assign w_funct      = id_inst[5:0];
  assign w_rs         = REG_AW'(id_inst[25:21]);
  assign w_rt         = REG_AW'(id_inst[20:16]);
  assign w_rd         = REG_AW'(id_inst[15:11]);
  assign unused_shamt = ^id_inst[10:6];

  ctl_t w_dec;
  logic w_illegal;

  always_comb begin
    w_dec     = '0;
    w_illegal = 1'b0;
    w_dec.rs  = w_rs;
    w_dec.rt  = w_rt;
    w_dec.dst = w_rt;
    case (w_op)
      C_OP_RTYPE: begin
        w_dec.dst    = w_rd;
        w_dec.wreg   = 1'b1;
        w_dec.use_rs = 1'b1;
        w_dec.use_rt = 1'b1;
        w_dec.aluc   = ALUC_W'(w_funct);
        case (w_funct)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: begin
            w_dec.shift = 1'b0;
          end
          6'h00, 6'h02, 6'h03: begin
            w_dec.shift  = 1'b1;
            w_dec.use_rs = 1'b0;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      C_OP_ADDI, C_OP_SLTI, C_OP_ANDI, C_OP_ORI, C_OP_LW: begin
        w_dec.wreg   = 1'b1;
        w_dec.aluimm = 1'b1;
        w_dec.use_rs = 1'b1;
        w_dec.m2reg  = (w_op == C_OP_LW);
        w_dec.sext   = (w_op == C_OP_ADDI) || (w_op == C_OP_SLTI) || (w_op == C_OP_LW);
        case (w_op)
          C_OP_SLTI: w_dec.aluc = C_ALU_SLT;
          C_OP_ANDI: w_dec.aluc = C_ALU_AND;
          C_OP_ORI:  w_dec.aluc = C_ALU_OR;
          default:   w_dec.aluc = C_ALU_ADD;
        endcase
      end
      C_OP_SW: begin
        w_dec.wmem   = 1'b1;
        w_dec.aluimm = 1'b1;
        w_dec.sext   = 1'b1;
        w_dec.aluc   = C_ALU_ADD;
        w_dec.use_rs = 1'b1;
        w_dec.use_rt = 1'b1;
      end
      C_OP_BEQ, C_OP_BNE: begin
        w_dec.branch = 1'b1;
        w_dec.bne    = (w_op == C_OP_BNE);
        w_dec.sext   = 1'b1;
        w_dec.aluc   = C_ALU_SUB;
        w_dec.use_rs = 1'b1;
        w_dec.use_rt = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_dec = '0;
    end
    if (w_dec.dst == '0) begin
      w_dec.wreg = 1'b0;
    end
  end

  ctl_t              r_ex;
  logic              r_mem_wreg, r_mem_m2reg, r_mem_wmem;
  logic [REG_AW-1:0] r_mem_dst;
  logic              r_wb_wreg, r_wb_m2reg;
  logic [REG_AW-1:0] r_wb_dst;
  logic              r_illegal;

  // Source-match terms for the ID instruction against each older producer.
  logic w_hit_ex, w_hit_mem, w_load_use, w_raw, w_hazard, w_stall, w_flush, w_bubble;

  assign w_hit_ex   = (r_ex.dst != '0) &&
                      ((w_dec.use_rs && (w_dec.rs == r_ex.dst)) ||
                       (w_dec.use_rt && (w_dec.rt == r_ex.dst)));
  assign w_hit_mem  = (r_mem_dst != '0) &&
                      ((w_dec.use_rs && (w_dec.rs == r_mem_dst)) ||
                       (w_dec.use_rt && (w_dec.rt == r_mem_dst)));
  assign w_load_use = r_ex.m2reg && w_hit_ex;
  assign w_raw      = (r_ex.wreg && w_hit_ex) || (r_mem_wreg && w_hit_mem);
  assign w_hazard   = (FWD_EN != 0) ? w_load_use : (w_load_use || w_raw);
  assign w_flush    = !rst && branch_taken;
  assign w_stall    = !rst && !branch_taken && id_valid && w_hazard;
  assign w_bubble   = w_stall || w_flush || !id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= '0;
      r_mem_wreg  <= 1'b0;
      r_mem_m2reg <= 1'b0;
      r_mem_wmem  <= 1'b0;
      r_mem_dst   <= '0;
      r_wb_wreg   <= 1'b0;
      r_wb_m2reg  <= 1'b0;
      r_wb_dst    <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_ex        <= w_bubble ? '0 : w_dec;
      r_illegal   <= !w_bubble && w_illegal;
      r_mem_wreg  <= r_ex.wreg;
      r_mem_m2reg <= r_ex.m2reg;
      r_mem_wmem  <= r_ex.wmem;
      r_mem_dst   <= r_ex.dst;
      r_wb_wreg   <= r_mem_wreg;
      r_wb_m2reg  <= r_mem_m2reg;
      r_wb_dst    <= r_mem_dst;
    end
  end

  // EX/MEM has priority over MEM/WB because it holds the younger result.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if ((FWD_EN != 0) && !rst) begin
      if (r_ex.use_rs && r_mem_wreg && (r_mem_dst != '0) && (r_mem_dst == r_ex.rs)) begin
        fwd_a = 2'b01;
      end else if (r_ex.use_rs && r_wb_wreg && (r_wb_dst != '0) && (r_wb_dst == r_ex.rs)) begin
        fwd_a = 2'b10;
      end
      if (r_ex.use_rt && r_mem_wreg && (r_mem_dst != '0) && (r_mem_dst == r_ex.rt)) begin
        fwd_b = 2'b01;
      end else if (r_ex.use_rt && r_wb_wreg && (r_wb_dst != '0) && (r_wb_dst == r_ex.rt)) begin
        fwd_b = 2'b10;
      end
    end
  end

  assign cu_stall   = w_stall;
  assign cu_flush   = w_flush;
  assign cu_illegal = r_illegal;
  assign ex_wreg    = r_ex.wreg;
  assign ex_m2reg   = r_ex.m2reg;
  assign ex_wmem    = r_ex.wmem;
  assign ex_aluimm  = r_ex.aluimm;
  assign ex_shift   = r_ex.shift;
  assign ex_sext    = r_ex.sext;
  assign ex_branch  = r_ex.branch;
  assign ex_bne     = r_ex.bne;
  assign ex_aluc    = r_ex.aluc;
  assign ex_dst     = r_ex.dst;
  assign mem_wreg   = r_mem_wreg;
  assign mem_m2reg  = r_mem_m2reg;
  assign mem_wmem   = r_mem_wmem;
  assign mem_dst    = r_mem_dst;
  assign wb_wreg    = r_wb_wreg;
  assign wb_m2reg   = r_wb_m2reg;
  assign wb_dst     = r_wb_dst;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Purpose  : Scoreboard bench for pipe_ctrl_unit, forwarding and stall-only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

    localparam int S_STALL = 0, S_FLUSH = 1, S_ILL = 2, S_EXWREG = 3, S_EXM2REG = 4,
                   S_EXWMEM = 5, S_EXALUIMM = 6, S_EXSHIFT = 7, S_EXSEXT = 8,
                   S_EXBR = 9, S_EXBNE = 10, S_EXALUC = 11, S_EXDST = 12,
                   S_EXCTL = 13, S_MEMCTL = 14, S_WBCTL = 15, S_FWDA = 16, S_FWDB = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst [2];
    logic        id_valid [2];
    logic        branch_taken [2];
    logic        cu_stall [2], cu_flush [2], cu_illegal [2];
    logic        ex_wreg [2], ex_m2reg [2], ex_wmem [2], ex_aluimm [2];
    logic        ex_shift [2], ex_sext [2], ex_branch [2], ex_bne [2];
    logic [5:0]  ex_aluc [2];
    logic [4:0]  ex_dst [2], mem_dst [2], wb_dst [2];
    logic        mem_wreg [2], mem_m2reg [2], mem_wmem [2], wb_wreg [2], wb_m2reg [2];
    logic [1:0]  fwd_a [2], fwd_b [2];

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.ALUC_W(6), .REG_AW(5), .FWD_EN(1)) dut_fwd (
        .clk(clk), .rst(rst), .id_inst(id_inst[0]), .id_valid(id_valid[0]),
        .branch_taken(branch_taken[0]), .cu_stall(cu_stall[0]), .cu_flush(cu_flush[0]),
        .cu_illegal(cu_illegal[0]), .ex_wreg(ex_wreg[0]), .ex_m2reg(ex_m2reg[0]),
        .ex_wmem(ex_wmem[0]), .ex_aluimm(ex_aluimm[0]), .ex_shift(ex_shift[0]),
        .ex_sext(ex_sext[0]), .ex_branch(ex_branch[0]), .ex_bne(ex_bne[0]),
        .ex_aluc(ex_aluc[0]), .ex_dst(ex_dst[0]), .mem_wreg(mem_wreg[0]),
        .mem_m2reg(mem_m2reg[0]), .mem_wmem(mem_wmem[0]), .mem_dst(mem_dst[0]),
        .wb_wreg(wb_wreg[0]), .wb_m2reg(wb_m2reg[0]), .wb_dst(wb_dst[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0])
    );

    pipe_ctrl_unit #(.ALUC_W(6), .REG_AW(5), .FWD_EN(0)) dut_stall (
        .clk(clk), .rst(rst), .id_inst(id_inst[1]), .id_valid(id_valid[1]),
        .branch_taken(branch_taken[1]), .cu_stall(cu_stall[1]), .cu_flush(cu_flush[1]),
        .cu_illegal(cu_illegal[1]), .ex_wreg(ex_wreg[1]), .ex_m2reg(ex_m2reg[1]),
        .ex_wmem(ex_wmem[1]), .ex_aluimm(ex_aluimm[1]), .ex_shift(ex_shift[1]),
        .ex_sext(ex_sext[1]), .ex_branch(ex_branch[1]), .ex_bne(ex_bne[1]),
        .ex_aluc(ex_aluc[1]), .ex_dst(ex_dst[1]), .mem_wreg(mem_wreg[1]),
        .mem_m2reg(mem_m2reg[1]), .mem_wmem(mem_wmem[1]), .mem_dst(mem_dst[1]),
        .wb_wreg(wb_wreg[1]), .wb_m2reg(wb_m2reg[1]), .wb_dst(wb_dst[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1])
    );

    typedef struct {
        int          cyc;
        int          inst;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int n, input int sig);
        logic [31:0] v;
        v = '0;
        case (sig)
            S_STALL:    v = 32'(cu_stall[n]);
            S_FLUSH:    v = 32'(cu_flush[n]);
            S_ILL:      v = 32'(cu_illegal[n]);
            S_EXWREG:   v = 32'(ex_wreg[n]);
            S_EXM2REG:  v = 32'(ex_m2reg[n]);
            S_EXWMEM:   v = 32'(ex_wmem[n]);
            S_EXALUIMM: v = 32'(ex_aluimm[n]);
            S_EXSHIFT:  v = 32'(ex_shift[n]);
            S_EXSEXT:   v = 32'(ex_sext[n]);
            S_EXBR:     v = 32'(ex_branch[n]);
            S_EXBNE:    v = 32'(ex_bne[n]);
            S_EXALUC:   v = 32'(ex_aluc[n]);
            S_EXDST:    v = 32'(ex_dst[n]);
            S_EXCTL:    v = 32'({ex_wreg[n], ex_m2reg[n], ex_wmem[n], ex_aluimm[n], ex_shift[n],
                                 ex_sext[n], ex_branch[n], ex_bne[n], ex_aluc[n], ex_dst[n]});
            S_MEMCTL:   v = 32'({mem_wreg[n], mem_m2reg[n], mem_wmem[n], mem_dst[n]});
            S_WBCTL:    v = 32'({wb_wreg[n], wb_m2reg[n], wb_dst[n]});
            S_FWDA:     v = 32'(fwd_a[n]);
            S_FWDB:     v = 32'(fwd_b[n]);
            default:    v = 32'hdead_beef;
        endcase
        return v;
    endfunction

    // Monitor: retire every expectation scheduled for the current cycle.
    always @(negedge clk) begin : monitor
        int i;
        logic [31:0] act;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc <= cyc) begin
                checks = checks + 1;
                act = get_sig(exp_q[i].inst, exp_q[i].sig);
                if (exp_q[i].cyc < cyc || act !== exp_q[i].exp) begin
                    errors = errors + 1;
                    $display("FAIL %s (dut%0d cyc %0d): got 0x%0h expected 0x%0h",
                             exp_q[i].name, exp_q[i].inst, exp_q[i].cyc, act, exp_q[i].exp);
                end
                exp_q.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    task automatic expect_sig(input int n, input int sig, input logic [31:0] v,
                              input int dly, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.inst = n;
        e.sig  = sig;
        e.exp  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_inst[0] = 32'h8c010014; id_valid[0] = 1'b1; branch_taken[0] = 1'b0;
        id_inst[1] = 32'h0;        id_valid[1] = 1'b0; branch_taken[1] = 1'b0;

        // Reset held for two edges with lw r1 waiting in ID
        step();
        checks = checks + 1;
        if (ex_m2reg[0] !== 1'b0 || ex_wreg[0] !== 1'b0 || ex_dst[0] !== 5'd0) begin
            errors = errors + 1;
            $display("FAIL direct_rst_ex: m2reg %0b wreg %0b dst %0d", ex_m2reg[0], ex_wreg[0], ex_dst[0]);
        end
        expect_sig(0, S_STALL,  0, 0, "rst_stall");
        expect_sig(0, S_EXCTL,  0, 0, "rst_ex");
        expect_sig(0, S_MEMCTL, 0, 0, "rst_mem");
        expect_sig(0, S_WBCTL,  0, 0, "rst_wb");
        expect_sig(0, S_ILL,    0, 0, "rst_illegal");
        expect_sig(1, S_EXCTL,  0, 0, "rst_ex_nofwd");
        step();
        rst = 1'b0;
        expect_sig(0, S_EXM2REG,  1,      1, "lw_m2reg");
        expect_sig(0, S_EXDST,    1,      1, "lw_dst");
        expect_sig(0, S_EXALUC,   32'h20, 1, "lw_aluc");
        expect_sig(0, S_EXALUIMM, 1,      1, "lw_aluimm");
        expect_sig(0, S_EXWREG,   1,      1, "lw_wreg");

        // Load-use: add r3,r1,r2 behind lw r1
        step();
        checks = checks + 1;
        if (ex_m2reg[0] !== 1'b1 || ex_dst[0] !== 5'd1) begin
            errors = errors + 1;
            $display("FAIL direct_lw_ex: m2reg %0b dst %0d", ex_m2reg[0], ex_dst[0]);
        end
        id_inst[0] = 32'h00221820;
        expect_sig(0, S_STALL, 1, 0, "lu_stall");
        expect_sig(0, S_FLUSH, 0, 0, "lu_noflush");
        step();
        expect_sig(0, S_EXCTL,  0, 0, "lu_bubble");
        expect_sig(0, S_STALL,  0, 0, "lu_stall_end");
        expect_sig(0, S_MEMCTL, 32'hc1, 0, "lu_mem_lw");
        step();
        id_inst[0] = 32'h00430820;
        expect_sig(0, S_FWDA,  2, 0, "lu_fwd_a");
        expect_sig(0, S_FWDB,  0, 0, "lu_fwd_b");
        expect_sig(0, S_EXDST, 3, 0, "lu_add_dst");
        expect_sig(0, S_WBCTL, 32'h61, 0, "lu_wb_lw");
        expect_sig(0, S_STALL, 0, 0, "alu_no_stall1");

        // EX forwarding: add r1,r2,r3 then add r4,r1,r1
        step();
        id_inst[0] = 32'h00212020;
        expect_sig(0, S_STALL, 0, 0, "alu_no_stall2");
        expect_sig(0, S_FWDA,  0, 0, "add1_fwd_a");
        expect_sig(0, S_FWDB,  1, 0, "add1_fwd_b");
        step();
        id_inst[0] = 32'hac010004;
        expect_sig(0, S_FWDA,   1, 0, "exfwd_a");
        expect_sig(0, S_FWDB,   1, 0, "exfwd_b");
        expect_sig(0, S_STALL,  0, 0, "sw_no_stall");
        expect_sig(0, S_MEMCTL, 32'h81, 0, "mem_add_r1");

        // Store then branch
        step();
        id_inst[0] = 32'h10220003;
        expect_sig(0, S_EXWMEM,   1, 0, "sw_wmem");
        expect_sig(0, S_EXWREG,   0, 0, "sw_wreg");
        expect_sig(0, S_EXSEXT,   1, 0, "sw_sext");
        expect_sig(0, S_EXALUIMM, 1, 0, "sw_aluimm");
        expect_sig(0, S_FWDB,     2, 0, "sw_fwd_b_wb");
        expect_sig(0, S_FWDA,     0, 0, "sw_fwd_a_r0");
        step();
        branch_taken[0] = 1'b1;
        id_inst[0] = 32'h8c010014;
        expect_sig(0, S_EXBR,     1,      0, "beq_branch");
        expect_sig(0, S_EXBNE,    0,      0, "beq_bne");
        expect_sig(0, S_EXALUC,   32'h22, 0, "beq_aluc");
        expect_sig(0, S_EXWREG,   0,      0, "beq_wreg");
        expect_sig(0, S_EXALUIMM, 0,      0, "beq_aluimm");
        expect_sig(0, S_FLUSH,    1,      0, "br_flush");
        expect_sig(0, S_STALL,    0,      0, "br_stall");
        step();
        branch_taken[0] = 1'b0;
        expect_sig(0, S_EXCTL, 0, 0, "flush_bubble");
        expect_sig(0, S_FLUSH, 0, 0, "flush_end");

        // Flush overrides a pending load-use stall
        step();
        id_inst[0] = 32'h00221820;
        branch_taken[0] = 1'b1;
        expect_sig(0, S_EXM2REG, 1, 0, "ov_lw_in_ex");
        expect_sig(0, S_FLUSH,   1, 0, "ov_flush");
        expect_sig(0, S_STALL,   0, 0, "ov_stall");
        step();
        branch_taken[0] = 1'b0;
        id_inst[0] = 32'hfc000000;
        expect_sig(0, S_EXCTL,  0, 0, "ov_bubble");
        expect_sig(0, S_MEMCTL, 32'hc1, 0, "ov_mem_lw");
        expect_sig(0, S_ILL,    0, 0, "ill_before");

        // Illegal opcode, then r0 destination
        step();
        checks = checks + 1;
        if (cu_illegal[0] !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL direct_ill_pulse: got %0b", cu_illegal[0]);
        end
        id_inst[0] = 32'h00430020;
        expect_sig(0, S_EXCTL, 0, 0, "ill_bubble");
        expect_sig(0, S_ILL,   1, 0, "ill_pulse");
        expect_sig(0, S_WBCTL, 32'h61, 0, "ov_wb_lw");
        step();
        id_inst[0] = 32'h00021080;
        expect_sig(0, S_ILL,    0, 0, "ill_one_cycle");
        expect_sig(0, S_EXWREG, 0, 0, "r0_wreg");
        expect_sig(0, S_EXALUC, 32'h20, 0, "r0_aluc");
        expect_sig(0, S_EXDST,  0, 0, "r0_dst");

        // Shift and zero-extended immediate
        step();
        id_inst[0] = 32'h34450001;
        expect_sig(0, S_EXSHIFT, 1, 0, "sll_shift");
        expect_sig(0, S_EXALUC,  0, 0, "sll_aluc");
        expect_sig(0, S_EXDST,   2, 0, "sll_dst");
        expect_sig(0, S_EXWREG,  1, 0, "sll_wreg");
        expect_sig(0, S_STALL,   0, 0, "ori_no_stall");
        step();
        id_valid[0] = 1'b0;
        expect_sig(0, S_EXSEXT,   0,      0, "ori_sext");
        expect_sig(0, S_EXALUIMM, 1,      0, "ori_aluimm");
        expect_sig(0, S_EXALUC,   32'h25, 0, "ori_aluc");
        expect_sig(0, S_EXDST,    5,      0, "ori_dst");
        expect_sig(0, S_FWDA,     1,      0, "ori_fwd_a");
        step();
        expect_sig(0, S_EXCTL, 0, 0, "invalid_bubble");
        id_valid[0] = 1'b1;
        id_inst[0] = 32'h8c010014;

        // Reset during a load-use stall
        step();
        id_inst[0] = 32'h00221820;
        expect_sig(0, S_STALL, 1, 0, "pre_rst_stall");
        step();
        rst = 1'b1;
        expect_sig(0, S_STALL, 0, 0, "rst_forces_stall0");
        step();
        rst = 1'b0;
        id_valid[0] = 1'b0;
        expect_sig(0, S_EXCTL,  0, 0, "rst_mid_ex");
        expect_sig(0, S_MEMCTL, 0, 0, "rst_mid_mem");
        expect_sig(0, S_WBCTL,  0, 0, "rst_mid_wb");
        expect_sig(0, S_STALL,  0, 0, "rst_mid_stall");

        // Stall-only mode: add r1,r2,r3 then add r4,r1,r1
        id_inst[1] = 32'h00430820;
        id_valid[1] = 1'b1;
        step();
        id_inst[1] = 32'h00212020;
        expect_sig(1, S_STALL, 1, 0, "nf_stall1");
        expect_sig(1, S_FWDA,  0, 0, "nf_fwd_a1");
        expect_sig(1, S_FWDB,  0, 0, "nf_fwd_b1");
        step();
        expect_sig(1, S_STALL, 1, 0, "nf_stall2");
        expect_sig(1, S_EXCTL, 0, 0, "nf_bubble");
        expect_sig(1, S_FWDA,  0, 0, "nf_fwd_a2");
        expect_sig(1, S_FWDB,  0, 0, "nf_fwd_b2");
        step();
        expect_sig(1, S_STALL, 0, 0, "nf_stall_end");
        expect_sig(1, S_WBCTL, 32'h41, 0, "nf_wb_add");
        step();
        checks = checks + 1;
        if (ex_dst[1] !== 5'd4 || ex_wreg[1] !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL direct_nf_add: dst %0d wreg %0b", ex_dst[1], ex_wreg[1]);
        end
        id_valid[1] = 1'b0;
        expect_sig(1, S_EXDST,  4, 0, "nf_add_dst");
        expect_sig(1, S_EXWREG, 1, 0, "nf_add_wreg");
        expect_sig(1, S_FWDA,   0, 0, "nf_fwd_a3");

        repeat (3) step();
        while (exp_q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: got unchecked expected checked at cyc %0d", exp_q[0].name, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
